// File: rtl/weight_stream_loader.sv
// Streams the flat weight ROM image into the ann weight port, one layer at a time,
// with a single bubble cycle between layers and a one-cycle done pulse at the end.
module weight_stream_loader #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  output logic                            o_rom_en,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0]           i_rom_data,
  output logic                            o_weight_valid,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  output logic [DATA_WIDTH-1:0]           o_weight,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int L1_SIZE = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int L2_SIZE = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int L3_SIZE = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);

  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L1_LAST  = WEIGHT_COUNTER_WIDTH'(L1_SIZE - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L2_LAST  = WEIGHT_COUNTER_WIDTH'(L2_SIZE - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L3_LAST  = WEIGHT_COUNTER_WIDTH'(L3_SIZE - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] ADDR_ONE = WEIGHT_COUNTER_WIDTH'(1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] ADDR_ZERO = WEIGHT_COUNTER_WIDTH'(0);

  localparam logic [LAYER_WIDTH-1:0] LAYER_IDLE = LAYER_WIDTH'(2'b00);
  localparam logic [LAYER_WIDTH-1:0] LAYER_H1   = LAYER_WIDTH'(2'b01);
  localparam logic [LAYER_WIDTH-1:0] LAYER_H2   = LAYER_WIDTH'(2'b10);
  localparam logic [LAYER_WIDTH-1:0] LAYER_OUT  = LAYER_WIDTH'(2'b11);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_L1  = 3'd1,
    GAP_1    = 3'd2,
    LOAD_L2  = 3'd3,
    GAP_2    = 3'd4,
    LOAD_OUT = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t                          state_r;
  logic [WEIGHT_COUNTER_WIDTH-1:0] layer_addr_r;
  logic [LAYER_WIDTH-1:0]          fetch_layer_s;

  // Layer code of the word currently being fetched from the ROM.
  always_comb begin
    fetch_layer_s = LAYER_IDLE;
    case (state_r)
      LOAD_L1:  fetch_layer_s = LAYER_H1;
      LOAD_L2:  fetch_layer_s = LAYER_H2;
      LOAD_OUT: fetch_layer_s = LAYER_OUT;
      default:  fetch_layer_s = LAYER_IDLE;
    endcase
  end

  // Sequencer plus the one-stage beat pipeline that lines address/layer up with ROM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      layer_addr_r   <= ADDR_ZERO;
      o_rom_en       <= 1'b0;
      o_rom_addr     <= ADDR_ZERO;
      o_weight_valid <= 1'b0;
      o_weight_layer <= LAYER_IDLE;
      o_weight_addr  <= ADDR_ZERO;
      o_weight       <= {DATA_WIDTH{1'b0}};
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_done         <= 1'b0;
      o_weight_valid <= o_rom_en;
      if (o_rom_en) begin
        o_weight       <= i_rom_data;
        o_weight_addr  <= layer_addr_r;
        o_weight_layer <= fetch_layer_s;
      end else if (state_r == DONE) begin
        o_weight_layer <= LAYER_IDLE;
      end else begin
        o_weight_layer <= o_weight_layer;
      end

      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r      <= LOAD_L1;
            o_rom_en     <= 1'b1;
            o_rom_addr   <= ADDR_ZERO;
            layer_addr_r <= ADDR_ZERO;
            o_busy       <= 1'b1;
          end
        end
        LOAD_L1: begin
          if (layer_addr_r == L1_LAST) begin
            state_r  <= GAP_1;
            o_rom_en <= 1'b0;
          end else begin
            o_rom_addr   <= o_rom_addr + ADDR_ONE;
            layer_addr_r <= layer_addr_r + ADDR_ONE;
          end
        end
        GAP_1: begin
          state_r      <= LOAD_L2;
          o_rom_en     <= 1'b1;
          o_rom_addr   <= o_rom_addr + ADDR_ONE;
          layer_addr_r <= ADDR_ZERO;
        end
        LOAD_L2: begin
          if (layer_addr_r == L2_LAST) begin
            state_r  <= GAP_2;
            o_rom_en <= 1'b0;
          end else begin
            o_rom_addr   <= o_rom_addr + ADDR_ONE;
            layer_addr_r <= layer_addr_r + ADDR_ONE;
          end
        end
        GAP_2: begin
          state_r      <= LOAD_OUT;
          o_rom_en     <= 1'b1;
          o_rom_addr   <= o_rom_addr + ADDR_ONE;
          layer_addr_r <= ADDR_ZERO;
        end
        LOAD_OUT: begin
          if (layer_addr_r == L3_LAST) begin
            state_r  <= DONE;
            o_rom_en <= 1'b0;
          end else begin
            o_rom_addr   <= o_rom_addr + ADDR_ONE;
            layer_addr_r <= layer_addr_r + ADDR_ONE;
          end
        end
        // The last beat leaves the pipeline during this state.
        DONE: begin
          state_r <= IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          o_rom_en <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Bench for weight_stream_loader: a schedule model derived from layer sizes and
// start times is compared against every output on every cycle.
module tb_weight_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        o_rom_en;
  logic [10:0] o_rom_addr;
  logic [31:0] i_rom_data;
  logic        o_weight_valid;
  logic [1:0]  o_weight_layer;
  logic [10:0] o_weight_addr;
  logic [31:0] o_weight;
  logic        o_busy;
  logic        o_done;

  weight_stream_loader dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_weight_valid(o_weight_valid), .o_weight_layer(o_weight_layer),
    .o_weight_addr(o_weight_addr), .o_weight(o_weight),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // ROM image; garbage when not enabled so stray captures show up in o_weight
  assign i_rom_data = o_rom_en ? (32'h3F00_0000 + 32'(o_rom_addr)) : 32'hDEAD_BEEF;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int t_start = -1;
  int rst_lab = -10;
  int beats = 0;
  int ens = 0;
  logic [31:0] last_data = 32'h0;

  // Layer sizes 96 / 1056 / 99, bases 0 / 96 / 1152
  function automatic int layer_of(input int g);
    if (g < 96) return 1;
    else if (g < 1152) return 2;
    else return 3;
  endfunction

  function automatic int base_of(input int g);
    if (g < 96) return 0;
    else if (g < 1152) return 96;
    else return 1152;
  endfunction

  // ROM word fetched during label n of a run, or -1 (beat n+1 carries it)
  function automatic int fetch_at(input int n);
    if (n >= 1 && n <= 96) return n - 1;
    else if (n >= 98 && n <= 1153) return 96 + (n - 98);
    else if (n >= 1155 && n <= 1253) return 1152 + (n - 1155);
    else return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model bookkeeping on each rising edge: reset and start acceptance.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (!rst_n) begin
      t_start <= -1;
      rst_lab <= edge_cnt + 2;
    end else if (i_start && (t_start < 0 || (edge_cnt + 1 - t_start) >= 1255)) begin
      t_start <= edge_cnt + 1;
    end
  end

  int lit_n    [6] = '{2, 97, 98, 99, 1156, 1254};
  int lit_v    [6] = '{1, 1, 0, 1, 1, 1};
  int lit_lay  [6] = '{1, 1, 1, 2, 3, 3};
  int lit_addr [6] = '{0, 95, 0, 0, 0, 98};
  logic [31:0] lit_data [6] = '{32'h3F00_0000, 32'h3F00_005F, 32'h0,
                                32'h3F00_0060, 32'h3F00_0480, 32'h3F00_04E2};

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    int lab, n, g, gb, e_lay;
    logic e_en, e_v, e_busy, e_done;
    logic [31:0] e_data;
    lab = edge_cnt + 1;
    if (lab == rst_lab) begin
      chk("rst_rom_en", 32'(o_rom_en), 32'h0);
      chk("rst_rom_addr", 32'(o_rom_addr), 32'h0);
      chk("rst_valid", 32'(o_weight_valid), 32'h0);
      chk("rst_layer", 32'(o_weight_layer), 32'h0);
      chk("rst_waddr", 32'(o_weight_addr), 32'h0);
      chk("rst_weight", o_weight, 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      chk("rst_done", 32'(o_done), 32'h0);
      last_data = 32'h0;
    end else if (t_start < 0) begin
      chk("idle_rom_en", 32'(o_rom_en), 32'h0);
      chk("idle_valid", 32'(o_weight_valid), 32'h0);
      chk("idle_layer", 32'(o_weight_layer), 32'h0);
      chk("idle_busy", 32'(o_busy), 32'h0);
      chk("idle_done", 32'(o_done), 32'h0);
      chk("idle_weight_hold", o_weight, last_data);
    end else begin
      n = lab - t_start;
      g = fetch_at(n);
      gb = fetch_at(n - 1);
      e_en = (g >= 0);
      e_v = (gb >= 0);
      e_busy = (n >= 1 && n <= 1254);
      e_done = (n == 1255);
      if (e_v) e_lay = layer_of(gb);
      else if (n == 98) e_lay = 1;
      else if (n == 1155) e_lay = 2;
      else e_lay = 0;
      chk("rom_en", 32'(o_rom_en), 32'(e_en));
      if (e_en) chk("rom_addr", 32'(o_rom_addr), 32'(g));
      chk("valid", 32'(o_weight_valid), 32'(e_v));
      chk("layer", 32'(o_weight_layer), 32'(e_lay));
      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("done", 32'(o_done), 32'(e_done));
      if (e_v) begin
        e_data = 32'h3F00_0000 + 32'(gb);
        chk("waddr", 32'(o_weight_addr), 32'(gb - base_of(gb)));
        chk("weight", o_weight, e_data);
        last_data = e_data;
      end else begin
        chk("weight_hold", o_weight, last_data);
      end
      if (n == 1) begin
        beats = 0;
        ens = 0;
      end
      if (o_weight_valid) beats = beats + 1;
      if (o_rom_en) ens = ens + 1;
      if (n == 1255) begin
        chk("beat_count", 32'(beats), 32'd1251);
        chk("rom_en_count", 32'(ens), 32'd1251);
      end
      for (int i = 0; i < 6; i++) begin
        if (n == lit_n[i]) begin
          chk("lit_valid", 32'(o_weight_valid), 32'(lit_v[i]));
          chk("lit_layer", 32'(o_weight_layer), 32'(lit_lay[i]));
          if (lit_v[i] != 0) begin
            chk("lit_waddr", 32'(o_weight_addr), 32'(lit_addr[i]));
            chk("lit_weight", o_weight, lit_data[i]);
          end
        end
      end
    end
  end

  task automatic wait_lab(input int lab);
    int guard;
    guard = 0;
    while ((edge_cnt + 1) < lab && guard < 5000) begin
      @(negedge clk);
      guard = guard + 1;
    end
  endtask

  task automatic pulse_at(input int lab);
    wait_lab(lab);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  initial begin
    int t1, t2, t3;
    rst_n = 1'b0;
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    i_start = 1'b0;
    repeat (4) @(negedge clk);

    t1 = edge_cnt + 1;
    pulse_at(t1);
    pulse_at(t1 + 500);
    pulse_at(t1 + 1254);
    t2 = t1 + 1255;
    pulse_at(t2);

    wait_lab(t2 + 600);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    t3 = edge_cnt + 1;
    pulse_at(t3);
    wait_lab(t3 + 1262);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
